// File: rtl/ram_ctrl_if.sv
// Bus-side and program-port signals of the SAP-1 RAM controller.
// The tristate data bus is a plain inout on ram_ctrl itself.
interface ram_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic [AW-1:0] ABUS;
  logic          nLm;
  logic          nWE;
  logic          nCE;
  logic          PROG;
  logic [AW-1:0] P_ADDR;
  logic [DW-1:0] P_DATA;
  logic          P_VALID;
  logic          P_READY;
  logic          BUSY;
  logic [AW-1:0] ma;
  logic [DW-1:0] md;

  modport master (
    output ABUS, nLm, nWE, nCE, PROG, P_ADDR, P_DATA, P_VALID,
    input  P_READY, BUSY, ma, md
  );

  modport slave (
    input  ABUS, nLm, nWE, nCE, PROG, P_ADDR, P_DATA, P_VALID,
    output P_READY, BUSY, ma, md
  );
endinterface

// File: rtl/ram_ctrl.sv
// Clocked program/data RAM for the SAP-1 core: MAR, edge-triggered writes,
// post-reset hardware clear and a valid/ready program-load port.
module ram_ctrl #(
  parameter int DW             = 8,
  parameter int AW             = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          CLK,
  input  logic          nRST,
  inout  wire  [DW-1:0] DBUS,
  ram_ctrl_if.slave     bus
);
  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] LAST  = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_PROG  = 2'd2
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  state_t        state, state_nx;
  logic [AW-1:0] mar, mar_nx;
  logic [AW:0]   cnt, cnt_nx;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          rd_en;
  logic [DW-1:0] mem [DEPTH];

  always_comb begin
    state_nx = state;
    mar_nx   = mar;
    cnt_nx   = cnt;
    we       = 1'b0;
    waddr    = mar;
    wdata    = DBUS;
    case (state)
      S_CLEAR: begin
        we     = 1'b1;
        waddr  = cnt[AW-1:0];
        wdata  = '0;
        cnt_nx = cnt + 1'b1;
        if (cnt == LAST) state_nx = bus.PROG ? S_PROG : S_RUN;
      end
      S_RUN: begin
        // Write uses the pre-edge MAR even when nLm reloads it on the same edge.
        we = ~bus.nWE;
        if (!bus.nLm) mar_nx = bus.ABUS;
        if (bus.PROG) state_nx = S_PROG;
      end
      S_PROG: begin
        we    = bus.P_VALID;
        waddr = bus.P_ADDR;
        wdata = bus.P_DATA;
        if (bus.P_VALID) mar_nx = bus.P_ADDR;
        if (!bus.PROG) state_nx = S_RUN;
      end
      default: state_nx = RST_STATE;
    endcase
    // Edges seen while reset is held must never touch the array.
    if (!nRST) we = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RST_STATE;
      mar   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      mar   <= mar_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_en = nRST && (state == S_RUN) && !bus.nCE && bus.nWE;
  assign DBUS  = rd_en ? mem[mar] : {DW{1'bz}};

  assign bus.P_READY = (state == S_PROG);
  assign bus.BUSY    = (state == S_CLEAR);
  assign bus.ma      = mar;
  assign bus.md      = mem[mar];
endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: an 8x16 clearing instance and a 16x64
// instance whose contents survive reset.
module tb_ram_ctrl;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst0, rst1;
  ram_ctrl_if #(.DW(8),  .AW(4)) a ();
  ram_ctrl_if #(.DW(16), .AW(6)) b ();

  logic [7:0]  d0_drv;
  logic        d0_oe;
  wire  [7:0]  dbus0;
  logic [15:0] d1_drv;
  logic        d1_oe;
  wire  [15:0] dbus1;
  assign dbus0 = d0_oe ? d0_drv : 8'hzz;
  assign dbus1 = d1_oe ? d1_drv : 16'hzzzz;

  ram_ctrl #(.DW(8), .AW(4), .CLEAR_ON_RESET(1'b1)) dut0 (
    .CLK(CLK), .nRST(rst0), .DBUS(dbus0), .bus(a));
  ram_ctrl #(.DW(16), .AW(6), .CLEAR_ON_RESET(1'b0)) dut1 (
    .CLK(CLK), .nRST(rst1), .DBUS(dbus1), .bus(b));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic       v;
    logic [3:0] ad;
    logic [7:0] d;
  } pw_t;

  vec_t tbl [9];
  vec_t rbk [8];
  pw_t  pw  [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load0(input logic [3:0] ad);
    a.ABUS = ad; a.nLm = 1'b0; tick(); a.nLm = 1'b1;
  endtask

  task automatic write0(input logic [7:0] d);
    d0_drv = d; d0_oe = 1'b1; a.nWE = 1'b0; tick(); a.nWE = 1'b1; d0_oe = 1'b0;
  endtask

  task automatic load1(input logic [5:0] ad);
    b.ABUS = ad; b.nLm = 1'b0; tick(); b.nLm = 1'b1;
  endtask

  task automatic write1(input logic [15:0] d);
    d1_drv = d; d1_oe = 1'b1; b.nWE = 1'b0; tick(); b.nWE = 1'b1; d1_oe = 1'b0;
  endtask

  task automatic apply_vec(input string nm, input vec_t v);
    load0(v.addr);
    if (v.wr) write0(v.wdata);
    a.nCE = 1'b0;
    #1;
    chk({nm, "_dbus"}, 32'(dbus0), 32'(v.exp));
    chk({nm, "_md"},   32'(a.md),  32'(v.exp));
    chk({nm, "_ma"},   32'(a.ma),  32'(v.addr));
    a.nCE = 1'b1;
    #1;
  endtask

  task automatic count_busy(input string nm, input int exp);
    int n = 0;
    while (a.BUSY && n < 40) begin
      tick();
      n++;
    end
    chk(nm, 32'(n), 32'(exp));
  endtask

  initial begin
    logic [3:0] exp_ma;

    tbl[0] = '{4'h3, 1'b1, 8'h5C, 8'h5C};
    tbl[1] = '{4'h9, 1'b1, 8'hA7, 8'hA7};
    tbl[2] = '{4'h3, 1'b0, 8'h00, 8'h5C};
    tbl[3] = '{4'h3, 1'b1, 8'hC3, 8'hC3};
    tbl[4] = '{4'h9, 1'b0, 8'h00, 8'hA7};
    tbl[5] = '{4'hF, 1'b1, 8'h01, 8'h01};
    tbl[6] = '{4'h3, 1'b0, 8'h00, 8'hC3};
    tbl[7] = '{4'h0, 1'b0, 8'h00, 8'h00};
    tbl[8] = '{4'hF, 1'b0, 8'h00, 8'h01};

    pw[0] = '{1'b1, 4'h0, 8'h1E};
    pw[1] = '{1'b0, 4'h2, 8'h99};
    pw[2] = '{1'b1, 4'h1, 8'h2F};
    pw[3] = '{1'b0, 4'h3, 8'h88};
    pw[4] = '{1'b1, 4'hF, 8'hFF};
    pw[5] = '{1'b0, 4'h6, 8'h77};

    rbk[0] = '{4'h0, 1'b0, 8'h00, 8'h1E};
    rbk[1] = '{4'h1, 1'b0, 8'h00, 8'h2F};
    rbk[2] = '{4'hF, 1'b0, 8'h00, 8'hFF};
    rbk[3] = '{4'h4, 1'b0, 8'h00, 8'h44};
    rbk[4] = '{4'h2, 1'b0, 8'h00, 8'h11};
    rbk[5] = '{4'h3, 1'b0, 8'h00, 8'hC3};
    rbk[6] = '{4'h6, 1'b0, 8'h00, 8'h00};
    rbk[7] = '{4'h7, 1'b0, 8'h00, 8'h77};

    a.ABUS = '0; a.nLm = 1'b1; a.nWE = 1'b1; a.nCE = 1'b1; a.PROG = 1'b0;
    a.P_ADDR = '0; a.P_DATA = '0; a.P_VALID = 1'b0;
    b.ABUS = '0; b.nLm = 1'b1; b.nWE = 1'b1; b.nCE = 1'b1; b.PROG = 1'b0;
    b.P_ADDR = '0; b.P_DATA = '0; b.P_VALID = 1'b0;
    d0_drv = '0; d0_oe = 1'b0; d1_drv = '0; d1_oe = 1'b0;
    rst0 = 1'b0; rst1 = 1'b0;
    tick(); tick();

    chk("rst_busy0",  32'(a.BUSY),      32'd1);
    chk("rst_rdy0",   32'(a.P_READY),   32'd0);
    chk("rst_ma0",    32'(a.ma),        32'd0);
    chk("rst_drv0",   32'(dut0.rd_en),  32'd0);
    chk("rst_busy1",  32'(b.BUSY),      32'd0);
    chk("rst_ma1",    32'(b.ma),        32'd0);

    rst0 = 1'b1; rst1 = 1'b1;
    count_busy("clear_len_first", 16);

    // Preload address 5, then confirm a reset pulse wipes it.
    a.PROG = 1'b1; tick();
    chk("pre_ready", 32'(a.P_READY), 32'd1);
    a.P_ADDR = 4'h5; a.P_DATA = 8'hA5; a.P_VALID = 1'b1; tick();
    a.P_VALID = 1'b0; a.PROG = 1'b0; tick();
    chk("pre_md", 32'(a.md), 32'h0A5);
    rst0 = 1'b0; #1;
    chk("pulse_busy", 32'(a.BUSY), 32'd1);
    tick(); rst0 = 1'b1;
    count_busy("clear_len_pulse", 16);
    chk("post_busy", 32'(a.BUSY), 32'd0);
    apply_vec("clr5", '{4'h5, 1'b0, 8'h00, 8'h00});

    // Reset in the middle of the clear restarts the count.
    rst0 = 1'b0; tick(); rst0 = 1'b1;
    repeat (5) tick();
    chk("mid_busy", 32'(a.BUSY), 32'd1);
    rst0 = 1'b0; tick(); rst0 = 1'b1;
    count_busy("clear_len_restart", 16);

    for (int i = 0; i < 9; i++) apply_vec($sformatf("run%0d", i), tbl[i]);
    chk("idle_nodrv", 32'(dut0.rd_en), 32'd0);

    // Write and MAR load on the same edge.
    load0(4'h7); write0(8'h77); load0(4'h2);
    a.ABUS = 4'h7; a.nLm = 1'b0; d0_drv = 8'h11; d0_oe = 1'b1; a.nWE = 1'b0;
    tick();
    a.nLm = 1'b1; a.nWE = 1'b1; d0_oe = 1'b0;
    chk("simul_ma", 32'(a.ma), 32'h7);
    chk("simul_md7", 32'(a.md), 32'h77);
    load0(4'h2);
    chk("simul_md2", 32'(a.md), 32'h11);

    chk("prog_rdy_before", 32'(a.P_READY), 32'd0);
    a.PROG = 1'b1; tick();
    chk("prog_rdy_after", 32'(a.P_READY), 32'd1);
    a.nWE = 1'b0; a.nCE = 1'b0; a.nLm = 1'b0; a.ABUS = 4'h6;
    d0_drv = 8'h00; d0_oe = 1'b1;
    exp_ma = 4'h2;
    for (int i = 0; i < 6; i++) begin
      a.P_VALID = pw[i].v; a.P_ADDR = pw[i].ad; a.P_DATA = pw[i].d;
      tick();
      if (pw[i].v) exp_ma = pw[i].ad;
      chk($sformatf("prog_ma%0d", i), 32'(a.ma), 32'(exp_ma));
      chk($sformatf("prog_nodrv%0d", i), 32'(dut0.rd_en), 32'd0);
    end
    a.nWE = 1'b1; a.nCE = 1'b1; a.nLm = 1'b1; d0_oe = 1'b0;
    a.PROG = 1'b0; a.P_VALID = 1'b1; a.P_ADDR = 4'h4; a.P_DATA = 8'h44;
    tick();
    a.P_VALID = 1'b0;
    chk("exit_rdy", 32'(a.P_READY), 32'd0);
    chk("exit_ma", 32'(a.ma), 32'h4);
    for (int i = 0; i < 8; i++) apply_vec($sformatf("rbk%0d", i), rbk[i]);

    // Bench drives the bus while a write and chip enable overlap.
    load0(4'hA);
    d0_drv = 8'h3C; d0_oe = 1'b1; a.nWE = 1'b0; a.nCE = 1'b0; #1;
    chk("cont_nodrv", 32'(dut0.rd_en), 32'd0);
    chk("cont_bus", 32'(dbus0), 32'h3C);
    tick();
    a.nWE = 1'b1; d0_oe = 1'b0; #1;
    chk("cont_rd", 32'(dbus0), 32'h3C);
    chk("cont_md", 32'(a.md), 32'h3C);
    a.nCE = 1'b1; #1;
    chk("cont_off", 32'(dut0.rd_en), 32'd0);

    // Non-clearing instance keeps its contents across reset.
    load1(6'd63); write1(16'hBEEF);
    chk("nc_md", 32'(b.md), 32'hBEEF);
    rst1 = 1'b0; #1;
    chk("nc_rst_busy", 32'(b.BUSY), 32'd0);
    chk("nc_rst_ma", 32'(b.ma), 32'd0);
    tick(); tick();
    rst1 = 1'b1; tick();
    chk("nc_busy", 32'(b.BUSY), 32'd0);
    chk("nc_ma", 32'(b.ma), 32'd0);
    load1(6'd63);
    b.nCE = 1'b0; #1;
    chk("nc_dbus", 32'(dbus1), 32'hBEEF);
    b.nCE = 1'b1;

    b.PROG = 1'b1; tick();
    b.P_ADDR = 6'd10; b.P_DATA = 16'h1234; b.P_VALID = 1'b1; tick();
    b.P_VALID = 1'b0;
    rst1 = 1'b0; #1;
    chk("nc_prog_rst_rdy", 32'(b.P_READY), 32'd0);
    b.PROG = 1'b0; tick();
    rst1 = 1'b1; tick();
    load1(6'd10);
    chk("nc_prog_kept", 32'(b.md), 32'h1234);
    load1(6'd63);
    chk("nc_beef_kept", 32'(b.md), 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
